fetch_mem_unit: RTL and testbench

//  Memory-side front end of the multi-cycle RV core. It holds PC, OldPC, IR and MDR, and turns the

---
 rtl/fetch_mem_unit.sv | 175 +++++++++++++++++
 tb/tb_fetch_mem_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_mem_unit.sv
// Memory-side front end of the multi-cycle core: PC, OldPC, IR, MDR and a
// single-outstanding req/ready bus master that stalls the controller per access.
module fetch_mem_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 255,
  parameter int              TMO_W    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ir_write,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            adr_src,
  input  logic            pc_write,
  input  logic [XLEN-1:0] pc_next,
  input  logic [XLEN-1:0] data_addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] old_pc,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] mdr,
  output logic            stall,
  output logic            fault,
  output logic [1:0]      fault_cause,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE, S_FAULT} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d, instr_q, instr_d, old_pc_q, old_pc_d, mdr_q, mdr_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic              is_fetch_q, is_fetch_d, is_load_q, is_load_d;
  logic              fault_q, fault_d;
  logic [1:0]        cause_q, cause_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  logic              req, multi;
  logic [XLEN-1:0]   addr;

  assign req   = ir_write | mem_read | mem_write;
  assign multi = (ir_write & mem_read) | (ir_write & mem_write) | (mem_read & mem_write);
  assign addr  = adr_src ? data_addr : pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      old_pc_q    <= '0;
      mdr_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      is_fetch_q  <= 1'b0;
      is_load_q   <= 1'b0;
      fault_q     <= 1'b0;
      cause_q     <= 2'b00;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      old_pc_q    <= old_pc_d;
      mdr_q       <= mdr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      is_fetch_q  <= is_fetch_d;
      is_load_q   <= is_load_d;
      fault_q     <= fault_d;
      cause_q     <= cause_d;
      tmo_q       <= tmo_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    old_pc_d    = old_pc_q;
    mdr_d       = mdr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    is_fetch_d  = is_fetch_q;
    is_load_d   = is_load_q;
    fault_d     = fault_q;
    cause_d     = cause_q;
    tmo_d       = tmo_q;
    // PC only moves when the controller is free to leave its state.
    pc_d        = (pc_write && !stall) ? pc_next : pc_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          if (multi) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
            cause_d = 2'b11;
          end else if (addr[1:0] != 2'b00) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
            cause_d = 2'b01;
          end else begin
            state_d     = S_BUSY;
            mem_req_d   = 1'b1;
            mem_we_d    = mem_write;
            mem_addr_d  = addr;
            mem_wdata_d = wdata;
            is_fetch_d  = ir_write;
            is_load_d   = mem_read;
            tmo_d       = '0;
          end
        end
      end
      S_BUSY: begin
        if (mem_ready) begin
          state_d   = S_DONE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          tmo_d     = '0;
          if (is_fetch_q) begin
            instr_d  = mem_rdata;
            old_pc_d = mem_addr_q;
          end
          if (is_load_q) mdr_d = mem_rdata;
        end else if (tmo_q == TMO_W'(TIMEOUT)) begin
          state_d   = S_FAULT;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          fault_d   = 1'b1;
          cause_d   = 2'b10;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      // Strobes seen here belong to the access that just finished.
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall = 1'b1;
    unique case (state_q)
      S_IDLE:  stall = req;
      S_BUSY:  stall = 1'b1;
      S_DONE:  stall = 1'b0;
      S_FAULT: stall = 1'b1;
      default: stall = 1'b1;
    endcase
  end

  assign instr       = instr_q;
  assign old_pc      = old_pc_q;
  assign pc          = pc_q;
  assign mdr         = mdr_q;
  assign fault       = fault_q;
  assign fault_cause = cause_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_fetch_mem_unit.sv
// Directed bench for fetch_mem_unit: bench acts as controller and memory,
// with a queue of expected bus requests checked as the DUT issues them.
module tb_fetch_mem_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ir_write, mem_read, mem_write, adr_src, pc_write;
  logic [31:0] pc_next, data_addr, wdata;
  logic [31:0] instr, old_pc, pc, mdr;
  logic        stall, fault;
  logic [1:0]  fault_cause;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;

  always #5 clk = ~clk;

  fetch_mem_unit dut (
    .clk(clk), .rst_n(rst_n),
    .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .adr_src(adr_src), .pc_write(pc_write), .pc_next(pc_next),
    .data_addr(data_addr), .wdata(wdata),
    .instr(instr), .old_pc(old_pc), .pc(pc), .mdr(mdr),
    .stall(stall), .fault(fault), .fault_cause(fault_cause),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  req_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] pc_m, instr_m, old_pc_m, mdr_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    ir_write  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    adr_src   = 1'b0;
    pc_write  = 1'b0;
    pc_next   = '0;
    data_addr = '0;
    wdata     = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_old_pc", old_pc, 32'h0);
    chk("rst_mdr", mdr, 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_cause", 32'(fault_cause), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    pc_m = 32'h0; instr_m = '0; old_pc_m = '0; mdr_m = '0;
    exp_q.delete();
    $display("reset: done at %0t", $time);
  endtask

  // One controller state issuing one access; memory answers after 'waits' BUSY cycles.
  task automatic do_access(input string name, input logic f, input logic r, input logic w,
                           input logic asrc, input logic [31:0] daddr, input logic [31:0] wd,
                           input logic [31:0] rd, input int waits, input logic pcw,
                           input logic [31:0] pcn, input int exp_stall, input int exp_req);
    req_t        e, cur;
    int          stalls = 0, reqs = 0, wcnt = 0, cyc = 0;
    logic        seen = 1'b0, done = 1'b0;
    logic [31:0] a;
    a = asrc ? daddr : pc_m;
    ir_write = f; mem_read = r; mem_write = w; adr_src = asrc;
    data_addr = daddr; wdata = wd; pc_write = pcw; pc_next = pcn;
    e.we = w; e.addr = a; e.wdata = w ? wd : 32'h0;
    if (!w) e.wdata = wd;
    exp_q.push_back(e);
    cur = e;
    while (!done && cyc < 400) begin
      #1;
      cyc++;
      if (mem_req) begin
        reqs++;
        if (!seen) begin
          seen = 1'b1;
          cur = exp_q.pop_front();
        end
        chk({name, "_mem_addr"}, mem_addr, cur.addr);
        chk({name, "_mem_we"}, 32'(mem_we), 32'(cur.we));
        chk({name, "_mem_wdata"}, mem_wdata, cur.wdata);
        if (wcnt == waits) begin
          mem_ready = 1'b1;
          mem_rdata = rd;
        end else begin
          wcnt++;
        end
      end
      if (stall) begin
        stalls++;
        chk({name, "_pc_hold"}, pc, pc_m);
      end else begin
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      mem_rdata = '0;
    end
    idle_inputs();
    if (f) begin instr_m = rd; old_pc_m = a; end
    if (r) mdr_m = rd;
    if (pcw) pc_m = pcn;
    chk({name, "_completed"}, 32'(done), 32'h1);
    chk({name, "_instr"}, instr, instr_m);
    chk({name, "_old_pc"}, old_pc, old_pc_m);
    chk({name, "_mdr"}, mdr, mdr_m);
    chk({name, "_pc"}, pc, pc_m);
    chk({name, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
    chk({name, "_req_cycles"}, 32'(reqs), 32'(exp_req));
    chk({name, "_fault"}, 32'(fault), 32'h0);
    $display("access %s: addr=%h we=%0d rdata=%h stalls=%0d reqs=%0d", name, a, w, rd, stalls, reqs);
  endtask

  task automatic do_fault(input string name, input logic f, input logic r, input logic w,
                          input logic asrc, input logic [31:0] daddr, input logic [1:0] cause,
                          input int ncyc, input int exp_req);
    int reqs = 0, stalls = 0;
    ir_write = f; mem_read = r; mem_write = w; adr_src = asrc; data_addr = daddr;
    for (int i = 0; i < ncyc; i++) begin
      #1;
      if (mem_req) reqs++;
      if (stall) stalls++;
      tick();
    end
    idle_inputs();
    chk({name, "_fault"}, 32'(fault), 32'h1);
    chk({name, "_cause"}, 32'(fault_cause), 32'(cause));
    chk({name, "_req_cycles"}, 32'(reqs), 32'(exp_req));
    chk({name, "_stall_cycles"}, 32'(stalls), 32'(ncyc));
    tick();
    tick();
    #1;
    chk({name, "_stall_sticky"}, 32'(stall), 32'h1);
    chk({name, "_cause_sticky"}, 32'(fault_cause), 32'(cause));
    chk({name, "_req_idle"}, 32'(mem_req), 32'h0);
    $display("fault %s: cause=%b reqs=%0d", name, fault_cause, reqs);
    do_reset();
  endtask

  initial begin
    idle_inputs();
    do_reset();

    do_access("fetch0", 1, 0, 0, 0, 32'h0, 32'h0, 32'h00A00093, 0, 1, 32'h4, 2, 1);
    do_access("fetch4", 1, 0, 0, 0, 32'h0, 32'h0, 32'h00208133, 2, 1, 32'h8, 4, 3);
    do_access("load100", 0, 1, 0, 1, 32'h100, 32'h0, 32'hDEADBEEF, 3, 0, 32'h0, 5, 4);
    do_access("store104", 0, 0, 1, 1, 32'h104, 32'h12345678, 32'hFFFFFFFF, 1, 0, 32'h0, 3, 2);
    do_access("fetch8", 1, 0, 0, 0, 32'h0, 32'h0, 32'h0000A083, 0, 1, 32'hC, 2, 1);

    // Reset in the middle of a load.
    mem_read = 1'b1; adr_src = 1'b1; data_addr = 32'h200;
    tick();
    #1;
    chk("rstmid_req_up", 32'(mem_req), 32'h1);
    chk("rstmid_addr", mem_addr, 32'h200);
    #1;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("rstmid_req_drop", 32'(mem_req), 32'h0);
    chk("rstmid_pc", pc, 32'h0);
    $display("reset mid-access: mem_req=%0d pc=%h", mem_req, pc);
    tick();
    rst_n = 1'b1;
    pc_m = 32'h0; instr_m = '0; old_pc_m = '0; mdr_m = '0;
    exp_q.delete();
    do_access("fetch_clean", 1, 0, 0, 0, 32'h0, 32'h0, 32'h00100113, 1, 1, 32'h4, 3, 2);

    do_fault("misaligned", 0, 1, 0, 1, 32'h102, 2'b01, 5, 0);
    do_fault("multi", 1, 0, 1, 0, 32'h0, 2'b11, 5, 0);
    do_fault("timeout", 0, 1, 0, 1, 32'h100, 2'b10, 262, 256);

    do_access("fetch_after", 1, 0, 0, 0, 32'h0, 32'h0, 32'h00000013, 0, 1, 32'h4, 2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
